// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage memory access controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_access_ctrl_pkg;

    // Controller states; the encoding is fixed so that debug probes and
    // waveform decoders elsewhere in the pipeline can rely on it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam int unsigned DEF_TIMEOUT = 32;
    localparam int unsigned DEF_CW      = 8;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 16;

endpackage

// File: rtl/dff.sv
// Single-bit storage cell with asynchronous active-high clear.
// Latency: 1 cycle from d to q.
// Backpressure: none; the enclosing logic muxes d to implement hold.
module dff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // Capture d every edge; reset clears the cell immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_timeout_cnt.sv
// Cycle counter that watches how long an access has been outstanding.
// Latency: count updates 1 cycle after clr/inc; tc is combinational on the count.
// Backpressure: none; clr has priority over inc.
module mem_timeout_cnt #(
    parameter int unsigned TIMEOUT = 32,
    parameter int unsigned CW      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [CW-1:0] cnt;

    // Clear on entry to the wait phase, then count one per waiting cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Terminal count: this is the last cycle the memory is given to answer.
    assign tc = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: turns EX/MEM load/store fields into a req/done memory handshake.
// Latency: request in IDLE to data_valid is 3 cycles minimum, longer with mem_stall or slow mem_done.
// Backpressure: holds stall high until the access completes or the watchdog expires.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned CW      = DEF_CW
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr_in,
    input  logic [15:0] wdata_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_stall,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata,
    output logic        stall,
    output logic [15:0] rdata_out,
    output logic        data_valid,
    output logic        err
);

    state_t state_q;
    state_t state_d;

    logic        req_any;
    logic        ld_hold;
    logic        cap_rdata;
    logic        set_err;
    logic        cnt_clr;
    logic        cnt_inc;
    logic        cnt_tc;
    logic        err_q;

    logic        wr_d;
    logic        wr_q;
    logic [15:0] addr_d;
    logic [15:0] addr_q;
    logic [15:0] wdata_d;
    logic [15:0] wdata_q;
    logic [15:0] rdata_d;
    logic [15:0] rdata_q;

    assign req_any = mem_read_in | mem_write_in;
    assign ld_hold = (state_q == ST_IDLE) & req_any;

    // State register; reset abandons any in-flight memory transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        mem_en     = 1'b0;
        stall      = 1'b0;
        data_valid = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        cap_rdata  = 1'b0;
        set_err    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Stall immediately so EX/MEM keeps this instruction at the
                // next edge; gated by rst so reset drops stall at once.
                stall = req_any & ~rst;
                if (req_any) begin
                    state_d = ST_REQ;
                    // A simultaneous read+write is executed as a write but flagged.
                    set_err = mem_read_in & mem_write_in;
                end
            end
            ST_REQ: begin
                mem_en = 1'b1;
                stall  = 1'b1;
                if (!mem_stall) begin
                    state_d = ST_WAIT;
                    cnt_clr = 1'b1;
                end
            end
            ST_WAIT: begin
                stall   = 1'b1;
                cnt_inc = 1'b1;
                // A completion on the terminal-count cycle still counts as success.
                if (mem_done) begin
                    cap_rdata = ~wr_q;
                    state_d   = ST_DONE;
                end else if (cnt_tc) begin
                    set_err = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Pipeline advances this cycle, so never loop back into REQ.
                data_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky error flag; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (set_err) begin
            err_q <= 1'b1;
        end
    end

    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_timeout_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .tc  (cnt_tc)
    );

    // Hold-or-load muxes in front of the storage cells.
    assign wr_d    = ld_hold   ? mem_write_in : wr_q;
    assign addr_d  = ld_hold   ? addr_in      : addr_q;
    assign wdata_d = ld_hold   ? wdata_in     : wdata_q;
    assign rdata_d = cap_rdata ? mem_rdata    : rdata_q;

    dff u_wr (
        .clk (clk),
        .rst (rst),
        .d   (wr_d),
        .q   (wr_q)
    );

    for (genvar i = 0; i < 16; i++) begin : g_hold
        dff u_addr (
            .clk (clk),
            .rst (rst),
            .d   (addr_d[i]),
            .q   (addr_q[i])
        );
        dff u_wdata (
            .clk (clk),
            .rst (rst),
            .d   (wdata_d[i]),
            .q   (wdata_q[i])
        );
        dff u_rdata (
            .clk (clk),
            .rst (rst),
            .d   (rdata_d[i]),
            .q   (rdata_q[i])
        );
    end

    assign mem_wr    = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata_out = rdata_q;
    assign err       = err_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Takes the registered memory request fields (address, store data, MemRead/MemWrite) and runs a multi-cycle request/done handshake to a stallable data memory.
- Stalls the pipeline until the access completes, then presents load data and a one-cycle valid toward the MEM/WB register.
- Timeout watchdog flags a memory that never completes.

Parameters:
- TIMEOUT, 32: max cycles in WAIT before abandoning the access; legal range 2..255.
- CW, 8: width of the timeout counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- addr_in  in  16  effective address from EX/MEM
- wdata_in  in  16  store data from EX/MEM
- mem_read_in  in  1  load request from EX/MEM
- mem_write_in  in  1  store request from EX/MEM
- mem_en  out  1  request strobe to memory
- mem_wr  out  1  1 = write, 0 = read; valid while mem_en=1
- mem_addr  out  16  held address
- mem_wdata  out  16  held store data
- mem_stall  in  1  memory cannot accept a request this cycle
- mem_done  in  1  memory completed the outstanding access
- mem_rdata  in  16  read data; valid when mem_done=1
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- rdata_out  out  16  captured load data
- data_valid  out  1  one-cycle pulse when the access is complete
- err  out  1  sticky: timeout, or read and write requested together

Behaviour:
- Reset (async, rst=1) forces state IDLE, all outputs 0, holding registers 0, err 0, counter 0.

States and transitions:
- IDLE:
  - If mem_read_in or mem_write_in: latch addr_in, wdata_in and wr = mem_write_in into holding registers; go to REQ.
  - Otherwise stay in IDLE.
  - stall = (mem_read_in | mem_write_in) combinationally, so the EX/MEM contents hold at the next edge.
- REQ:
  - mem_en=1; mem_wr, mem_addr and mem_wdata come from the holding registers.
  - mem_stall=1: stay in REQ, keep mem_en asserted.
  - Otherwise go to WAIT and clear the counter.
  - stall=1.
- WAIT:
  - mem_en=0; counter increments each cycle.
  - mem_done=1: capture mem_rdata into rdata_out (reads only; writes leave rdata_out unchanged); go to DONE.
  - counter reaches TIMEOUT-1 without mem_done: set err, go to DONE with rdata_out unchanged.
  - stall=1.
- DONE:
  - data_valid=1, stall=0; the pipeline advances at the end of this cycle.
  - Next state is always IDLE, so the same instruction is never reissued.

Timing and boundary rules:
- Minimum latency from a request seen in IDLE to data_valid is 3 cycles (IDLE→REQ→WAIT with mem_done in the first WAIT cycle→DONE).
- mem_done arriving in the same cycle that the counter hits TIMEOUT-1: done wins, err is not set.
- mem_done arriving outside WAIT is ignored.
- mem_read_in and mem_write_in both 1 in IDLE: treated as a write, and err is set.
- rdata_out holds its value until the next read completes.
- Reset mid-access immediately drops mem_en and stall; the memory-side transaction is abandoned.
- err clears only on reset.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'b00, REQ=2'b01, WAIT=2'b10, DONE=2'b11
  - default TIMEOUT constant
- Holding registers and rdata_out use the existing dff cell, instantiated as arrays with enable muxes.
- One sub-module is natural: mem_timeout_cnt (clear, increment, terminal-count output).

Test Plan:
- Load: addr_in=16'h0040, mem_read_in=1, mem_done with mem_rdata=16'hBEEF in the first WAIT cycle → mem_en for 1 cycle with mem_wr=0 and mem_addr=16'h0040; data_valid at cycle 3; rdata_out=16'hBEEF; stall high for cycles 0-2 and low in cycle 3.
- Store: addr_in=16'h0010, wdata_in=16'h1234, mem_write_in=1, mem_stall high for 2 cycles → mem_en held 3 cycles with mem_wr=1 and mem_wdata=16'h1234; rdata_out unchanged; data_valid 1 cycle after mem_done.
- Timeout: read with mem_done never asserted, TIMEOUT=4 → err=1 after 4 WAIT cycles; data_valid pulses; FSM returns to IDLE; a following normal read completes correctly with err still 1.
- Back-to-back: two loads in consecutive instructions → two distinct mem_en bursts; exactly two data_valid pulses; no duplicate request for the first instruction.
- Conflict: mem_read_in=mem_write_in=1 → mem_wr=1 and err=1.
- Reset: assert rst during WAIT → stall, mem_en and data_valid go to 0 asynchronously; state is IDLE after release; a late mem_done is ignored.
